fetch_sequencer: RTL and testbench

//  Fetch-stage controller that drives the synchronous instruction ROM.

---
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/fetch_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: start/redirect control, ROM read port and decode handshake.
// master = fetch_sequencer, slave = environment (ROM, decode, branch unit).
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 24
);
    logic               start;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_rd_en;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               halted;

    modport master (
        input  start, rom_data, instr_ready, redirect, redirect_addr,
        output rom_addr, rom_rd_en, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output start, rom_data, instr_ready, redirect, redirect_addr,
        input  rom_addr, rom_rd_en, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues synchronous ROM reads, buffers
// returned instructions (output reg + skid) and presents them to decode over
// valid/ready. Handles redirects and stops on a HALT opcode.
// Optional build macro FETCH_PERF_EN adds perf_cycles/perf_stalls counters.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       INSTR_W      = 24,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [3:0]        HALT_OPCODE  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_cycles,
    output logic [15:0]       perf_stalls
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               infl_q, infl_d;
    logic [ADDR_W-1:0]  infl_pc_q, infl_pc_d;
    logic               out_v_q, out_v_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic               skid_v_q, skid_v_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

    // Program-ordered view of stored entries plus the returning ROM word.
    logic               head_v, next_v;
    logic [INSTR_W-1:0] head_instr, next_instr;
    logic [ADDR_W-1:0]  head_pc, next_pc;
    logic               pop, rd_en, halt_pop, flush;
    logic [1:0]         occ, fill;

    // The returning ROM word is presented directly when nothing older is
    // stored, so a read issued in cycle N is visible to decode in N+1.
    always_comb begin
        head_v     = infl_q;
        head_instr = bus.rom_data;
        head_pc    = infl_pc_q;
        next_v     = 1'b0;
        next_instr = bus.rom_data;
        next_pc    = infl_pc_q;
        if (out_v_q) begin
            head_v     = 1'b1;
            head_instr = out_instr_q;
            head_pc    = out_pc_q;
            next_v     = skid_v_q | infl_q;
            if (skid_v_q) begin
                next_instr = skid_instr_q;
                next_pc    = skid_pc_q;
            end
        end
    end

    assign bus.instr_valid = head_v;
    assign bus.instr       = head_v ? head_instr : '0;
    assign bus.instr_pc    = head_v ? head_pc : '0;
    assign bus.rom_addr    = pc_q;
    assign bus.rom_rd_en   = rd_en;
    assign bus.halted      = (state_q == ST_HALT);

    // Next-state, PC, read issue and buffer compaction.
    always_comb begin
        pop      = head_v & bus.instr_ready;
        halt_pop = pop & (head_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
        occ      = 2'(out_v_q) + 2'(skid_v_q);
        fill     = occ + 2'(infl_q) - 2'(pop);
        rd_en    = (state_q == ST_FETCH) & ~bus.redirect & (fill < 2'd2);

        state_d      = state_q;
        pc_d         = pc_q;
        infl_d       = rd_en;
        infl_pc_d    = pc_q;
        flush        = 1'b0;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (pop) begin
            out_v_d     = next_v;
            out_instr_d = next_instr;
            out_pc_d    = next_pc;
            skid_v_d    = 1'b0;
        end else begin
            out_v_d      = head_v;
            out_instr_d  = head_instr;
            out_pc_d     = head_pc;
            skid_v_d     = next_v;
            skid_instr_d = next_instr;
            skid_pc_d    = next_pc;
        end

        if (rd_en) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.redirect) pc_d = bus.redirect_addr;
                if (bus.start)    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    pc_d  = bus.redirect_addr;
                    flush = 1'b1;
                end else if (halt_pop) begin
                    state_d = ST_HALT;
                    flush   = 1'b1;
                end
            end
            ST_HALT: begin
                if (bus.redirect) begin
                    state_d = ST_FETCH;
                    pc_d    = bus.redirect_addr;
                    flush   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
            infl_d   = 1'b0;
        end
    end

    // State, PC and buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            out_v_q      <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            out_v_q      <= out_v_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_cycles_q, perf_cycles_d;
    logic [15:0] perf_stalls_q, perf_stalls_d;

    // Saturating counters of FETCH cycles and decode back-pressure cycles.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if ((state_q == ST_FETCH) && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 16'd1;
        if (head_v && !bus.instr_ready && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 16'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by randomized
// ready/redirect traffic, checked against a transaction-level model that
// tracks the next expected program address and the run/idle/halt mode.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(24)) bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] perf_cycles, perf_stalls;
    fetch_sequencer #(.ADDR_W(8), .INSTR_W(24), .RESET_VECTOR(8'h00), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
    );
`else
    fetch_sequencer #(.ADDR_W(8), .INSTR_W(24), .RESET_VECTOR(8'h00), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    function automatic logic [23:0] rom_word(input logic [7:0] a);
        if (a == 8'h20) return 24'hF00000;
        return {4'h1, 12'h000, a};
    endfunction

    // Synchronous ROM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rom_rd_en) bus.rom_data <= rom_word(bus.rom_addr);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
    mode_t       mode      = M_IDLE;
    logic [7:0]  exp_pc    = 8'h00;
    logic        redir_prev = 1'b0;
    logic        stall_prev = 1'b0;
    int          stall_run = 0;
    longint      cyc_n     = 0;
    longint      ev_cyc    = -1;
    int          xfer_cnt  = 0;
    int          run_cyc   = 0;
    int          stall_cyc = 0;

    task automatic model_check();
        logic xfer, stall, is_halt;
        if (reset) begin
            mode = M_IDLE; exp_pc = 8'h00; redir_prev = 1'b0; stall_prev = 1'b0;
            stall_run = 0; ev_cyc = -1; run_cyc = 0; stall_cyc = 0;
            return;
        end
        cyc_n++;
        xfer  = bus.instr_valid && bus.instr_ready;
        stall = bus.instr_valid && !bus.instr_ready;

        if (redir_prev) chk("redirect_bubble", 32'(bus.instr_valid), 32'h0);
        if (stall_prev) chk("stall_hold_valid", 32'(bus.instr_valid), 32'h1);
        if (bus.instr_valid) begin
            chk("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
            chk("instr", 32'(bus.instr), 32'(rom_word(exp_pc)));
        end
        if (stall && stall_run >= 1) chk("stall_rd_en", 32'(bus.rom_rd_en), 32'h0);
        if (ev_cyc == cyc_n) chk("first_valid_latency", 32'(bus.instr_valid), 32'h1);

        case (mode)
            M_IDLE: begin
                chk("idle_valid", 32'(bus.instr_valid), 32'h0);
                chk("idle_rd_en", 32'(bus.rom_rd_en), 32'h0);
                chk("idle_rom_addr", 32'(bus.rom_addr), 32'(exp_pc));
                chk("idle_halted", 32'(bus.halted), 32'h0);
            end
            M_RUN: chk("run_halted", 32'(bus.halted), 32'h0);
            M_HALT: begin
                chk("halt_halted", 32'(bus.halted), 32'h1);
                chk("halt_valid", 32'(bus.instr_valid), 32'h0);
                chk("halt_rd_en", 32'(bus.rom_rd_en), 32'h0);
            end
        endcase

        if (mode == M_RUN) run_cyc++;
        if (stall) stall_cyc++;
        if (xfer) xfer_cnt++;

        stall_prev = stall && !bus.redirect && (mode == M_RUN);
        stall_run  = (stall && !bus.redirect) ? stall_run + 1 : 0;
        redir_prev = bus.redirect && (mode != M_IDLE);

        case (mode)
            M_IDLE: begin
                if (bus.redirect) exp_pc = bus.redirect_addr;
                if (bus.start) begin
                    mode = M_RUN;
                    ev_cyc = cyc_n + 2;
                end
            end
            M_RUN: begin
                is_halt = xfer && (rom_word(exp_pc) == 24'hF00000);
                if (xfer) exp_pc = exp_pc + 8'd1;
                if (bus.redirect) begin
                    exp_pc = bus.redirect_addr;
                    ev_cyc = cyc_n + 2;
                end else if (is_halt) begin
                    mode = M_HALT;
                end
            end
            M_HALT: begin
                if (bus.redirect) begin
                    mode = M_RUN;
                    exp_pc = bus.redirect_addr;
                    ev_cyc = cyc_n + 2;
                end
            end
        endcase
    endtask

    // Called at posedge+1 with inputs set; checks at the falling edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_pc(input logic [7:0] target, input int unsigned limit, input string tag);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < limit && !found; i++) begin
            if (bus.instr_valid && bus.instr_pc == target) found = 1'b1;
            else tick();
        end
        chk(tag, 32'(found), 32'h1);
    endtask

    task automatic pulse_redirect(input logic [7:0] addr);
        bus.redirect = 1'b1;
        bus.redirect_addr = addr;
        tick();
        bus.redirect = 1'b0;
    endtask

    initial begin
        logic found;
        int   xfer_before;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_addr = 8'h00;
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_rd_en", 32'(bus.rom_rd_en), 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_instr", 32'(bus.instr), 32'h0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_cycles", 32'(perf_cycles), 32'h0);
        chk("rst_perf_stalls", 32'(perf_stalls), 32'h0);
`endif
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Start and stream with ready high.
        bus.start = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        run_until_pc(8'h05, 20, "reach_pc05");

        // Stall at 05 for three cycles.
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        bus.instr_ready = 1'b1;
        repeat (4) tick();

        // Redirect at 03 to 40.
        pulse_redirect(8'h00);
        run_until_pc(8'h03, 10, "reach_pc03");
        pulse_redirect(8'h40);
        repeat (4) tick();

        // Address wrap.
        pulse_redirect(8'hFE);
        repeat (6) tick();

        // Run into HALT, then leave it by redirect.
        pulse_redirect(8'h1C);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.halted) found = 1'b1;
            else tick();
        end
        chk("reach_halt", 32'(found), 32'h1);
        repeat (4) tick();
        pulse_redirect(8'h10);
        repeat (4) tick();

        // Reset while the buffer is full.
        bus.instr_ready = 1'b0;
        repeat (3) tick();
`ifdef FETCH_PERF_EN
        chk("perf_cycles", 32'(perf_cycles), 32'(run_cyc));
        chk("perf_stalls", 32'(perf_stalls), 32'(stall_cyc));
`endif
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.instr_valid), 32'h0);
        chk("midrst_rd_en", 32'(bus.rom_rd_en), 32'h0);
        chk("midrst_rom_addr", 32'(bus.rom_addr), 32'h0);
        chk("midrst_halted", 32'(bus.halted), 32'h0);
`ifdef FETCH_PERF_EN
        chk("midrst_perf_cycles", 32'(perf_cycles), 32'h0);
        chk("midrst_perf_stalls", 32'(perf_stalls), 32'h0);
`endif
        tick();
        tick();
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();

        // Randomized ready/redirect traffic.
        xfer_before = xfer_cnt;
        for (int i = 0; i < 400; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect = ($urandom_range(0, 15) == 0);
            bus.redirect_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h18, 8'h1F))
                                                           : 8'($urandom);
            bus.start = 1'($urandom_range(0, 1));
            tick();
        end
        bus.redirect = 1'b0;
        chk("random_progress", 32'(xfer_cnt > xfer_before + 50), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
